// File: rtl/xnor_pkg.sv
// Shared helpers for the XNOR compare/score family.
package xnor_pkg;
  localparam int XNOR_DEF_WIDTH   = 8;
  localparam int XNOR_DEF_WIN_LEN = 16;
  localparam int XNOR_DEF_CNT_W   = 16;

  // Bits needed to hold a count of 0..w set bits.
  function automatic int pc_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Width of a counter that indexes samples 0..n-1 (never narrower than 1).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/xnor_match_acc_popcount.sv
// Combinational popcount as a balanced adder tree, padded to a power-of-two leaf count.
module popcount
  import xnor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]           i_vec,
  output logic [pc_width(WIDTH)-1:0] o_cnt
);
  localparam int PW     = pc_width(WIDTH);
  localparam int LOG    = $clog2(WIDTH);
  localparam int LEAVES = 1 << LOG;

  // Every node is PW bits wide: no subtree can exceed WIDTH set bits.
  for (genvar l = 0; l <= LOG; l++) begin : g_lvl
    logic [PW-1:0] w_sum [LEAVES >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < LEAVES; i++) begin : g_bit
        if (i < WIDTH) begin : g_real
          assign w_sum[i] = PW'(i_vec[i]);
        end else begin : g_pad
          assign w_sum[i] = '0;
        end
      end
    end else begin : g_add
      for (genvar j = 0; j < (LEAVES >> l); j++) begin : g_node
        assign w_sum[j] = g_lvl[l-1].w_sum[2*j] + g_lvl[l-1].w_sum[2*j+1];
      end
    end
  end

  assign o_cnt = g_lvl[LOG].w_sum[0];
endmodule

// File: rtl/xnor_match_acc.sv
// Registered XNOR compare, per-sample match count, and windowed match statistics.
module xnor_match_acc
  import xnor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       clear,
  output logic                       y_valid,
  output logic [WIDTH-1:0]           y,
  output logic                       cnt_valid,
  output logic [pc_width(WIDTH)-1:0] match_cnt,
  output logic                       full_match,
  output logic                       win_done,
  output logic [CNT_W-1:0]           win_matches,
  output logic [CNT_W-1:0]           win_full_words
);
  localparam int PW = pc_width(WIDTH);
  localparam int SW = idx_width(WIN_LEN);

  if (((64'd1 << CNT_W) - 64'd1) < 64'(WIDTH) * 64'(WIN_LEN)) begin : g_bad_cnt_w
    $error("xnor_match_acc: CNT_W too narrow for WIDTH*WIN_LEN");
  end

  logic             r_y_valid, r_cnt_valid, r_full, r_win_done;
  logic [WIDTH-1:0] r_y;
  logic [PW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_acc_m, r_acc_f, r_win_m, r_win_f;
  logic [SW-1:0]    r_samp;
  logic [PW-1:0]    w_pc;
  logic             w_last;
  logic [CNT_W-1:0] w_sum_m, w_sum_f;

  popcount #(.WIDTH(WIDTH)) u_popcount (.i_vec(r_y), .o_cnt(w_pc));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_valid   <= 1'b0;
      r_y         <= '0;
      r_cnt_valid <= 1'b0;
      r_cnt       <= '0;
      r_full      <= 1'b0;
    end else begin
      r_y_valid   <= in_valid;
      if (in_valid) r_y <= ~(a ^ b);
      r_cnt_valid <= r_y_valid;
      if (r_y_valid) begin
        r_cnt  <= w_pc;
        r_full <= &r_y;
      end
    end
  end

  // Totals including the sample currently in stage 2.
  assign w_sum_m = r_acc_m + CNT_W'(r_cnt);
  assign w_sum_f = r_acc_f + CNT_W'(r_full);
  assign w_last  = (r_samp == SW'(WIN_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_m    <= '0;
      r_acc_f    <= '0;
      r_samp     <= '0;
      r_win_done <= 1'b0;
      r_win_m    <= '0;
      r_win_f    <= '0;
    end else begin
      r_win_done <= 1'b0;
      if (clear) begin
        r_acc_m <= '0;
        r_acc_f <= '0;
        r_samp  <= '0;
      end else if (r_cnt_valid) begin
        if (w_last) begin
          r_win_done <= 1'b1;
          r_win_m    <= w_sum_m;
          r_win_f    <= w_sum_f;
          r_acc_m    <= '0;
          r_acc_f    <= '0;
          r_samp     <= '0;
        end else begin
          r_acc_m <= w_sum_m;
          r_acc_f <= w_sum_f;
          r_samp  <= r_samp + SW'(1);
        end
      end
    end
  end

  assign y_valid        = r_y_valid;
  assign y              = r_y;
  assign cnt_valid      = r_cnt_valid;
  assign match_cnt      = r_cnt;
  assign full_match     = r_full;
  assign win_done       = r_win_done;
  assign win_matches    = r_win_m;
  assign win_full_words = r_win_f;
endmodule
